// File: rtl/alu_cmd_if.sv
// Command / result / ALU bus bundle for alu_cmd_initiator.
// master: the initiator's view. slave: the sequencer + ALU side.
interface alu_cmd_if #(
    parameter int DATA_W = 256
);
    // Sequencer command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_op;
    logic [7:0]        cmd_scalar;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    // Result channel
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    // Matrix ALU port set
    logic              alu_enable;
    logic              alu_rw;
    logic [7:0]        alu_opcode;
    logic [DATA_W-1:0] alu_in;
    logic [DATA_W-1:0] alu_out;
    logic              alu_status;

    modport master (
        input  cmd_valid, cmd_op, cmd_scalar, cmd_a, cmd_b,
        output cmd_ready,
        output res_valid, res_data, res_err,
        input  res_ready,
        output alu_enable, alu_rw, alu_opcode, alu_in,
        input  alu_out, alu_status
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_scalar, cmd_a, cmd_b,
        input  cmd_ready,
        input  res_valid, res_data, res_err,
        output res_ready,
        input  alu_enable, alu_rw, alu_opcode, alu_in,
        output alu_out, alu_status
    );
endinterface

// File: rtl/alu_cmd_initiator.sv
// alu_cmd_initiator: takes one matrix command, drives the matrix ALU through
// operand writes, the opcode cycle, a status wait and a read cycle, then
// returns the 256-bit result (or an error) on the result channel.
//
// Handshakes (cmd and res): a transfer happens on the rising edge where
// valid & ready are both high; the source holds its payload stable while
// valid is high and ready is low.
//
// Optional build macro ALU_OP_CHECK_EN: when defined, unknown opcodes are
// answered with res_err=1 without touching the ALU bus. When undefined, any
// opcode other than trans/scale is run as a binary operation.
module alu_cmd_initiator #(
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    alu_cmd_if.master   bus,
    output logic [3:0]  dbg_state_o
);

    localparam logic [7:0] OP_ADD   = 8'h81;
    localparam logic [7:0] OP_SUB   = 8'h82;
    localparam logic [7:0] OP_MULT  = 8'h83;
    localparam logic [7:0] OP_TRANS = 8'h85;
    localparam logic [7:0] OP_SCALE = 8'hBC;
    localparam logic [7:0] OP_DATA  = 8'h01;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WR_A = 4'd1,
        S_WR_B = 4'd2,
        S_OP   = 4'd3,
        S_WAIT = 4'd4,
        S_RD   = 4'd5,
        S_CAP  = 4'd6,
        S_DONE = 4'd7,
        S_ERR  = 4'd8
    } state_t;

    state_t            state_q;
    logic              cmd_ready_q;
    logic              res_valid_q;
    logic              res_err_q;
    logic [DATA_W-1:0] res_data_q;
    logic              alu_enable_q;
    logic              alu_rw_q;
    logic [7:0]        alu_opcode_q;
    logic [DATA_W-1:0] alu_in_q;
    logic [7:0]        op_q;
    logic [7:0]        scalar_q;
    logic [DATA_W-1:0] b_q;
    logic [TO_W-1:0]   to_cnt_q;

    logic              op_unary;
    logic              cmd_accept;

    // Decode of the latched opcode and of the accept condition
    always_comb begin
        op_unary   = (op_q == OP_TRANS) || (op_q == OP_SCALE);
        cmd_accept = bus.cmd_valid && cmd_ready_q;
    end

`ifdef ALU_OP_CHECK_EN
    logic cmd_known;

    // Opcode legality check on the offered command
    always_comb begin
        cmd_known = (bus.cmd_op == OP_ADD)   || (bus.cmd_op == OP_SUB)  ||
                    (bus.cmd_op == OP_MULT)  || (bus.cmd_op == OP_TRANS) ||
                    (bus.cmd_op == OP_SCALE);
    end
`endif

    // Sequencing FSM; every output is a register updated with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b1;
            res_valid_q  <= 1'b0;
            res_err_q    <= 1'b0;
            res_data_q   <= '0;
            alu_enable_q <= 1'b0;
            alu_rw_q     <= 1'b0;
            alu_opcode_q <= 8'h00;
            alu_in_q     <= '0;
            op_q         <= 8'h00;
            scalar_q     <= 8'h00;
            b_q          <= '0;
            to_cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_accept) begin
                        op_q        <= bus.cmd_op;
                        scalar_q    <= bus.cmd_scalar;
                        b_q         <= bus.cmd_b;
                        cmd_ready_q <= 1'b0;
                        res_err_q   <= 1'b0;
`ifdef ALU_OP_CHECK_EN
                        if (!cmd_known) begin
                            // Rejected op: bus stays idle, error reported next edge
                            state_q <= S_ERR;
                        end else begin
                            state_q      <= S_WR_A;
                            alu_enable_q <= 1'b1;
                            alu_rw_q     <= 1'b0;
                            alu_opcode_q <= OP_DATA;
                            alu_in_q     <= bus.cmd_a;
                        end
`else
                        state_q      <= S_WR_A;
                        alu_enable_q <= 1'b1;
                        alu_rw_q     <= 1'b0;
                        alu_opcode_q <= OP_DATA;
                        alu_in_q     <= bus.cmd_a;
`endif
                    end
                end
                S_WR_A: begin
                    if (op_unary) begin
                        state_q      <= S_OP;
                        alu_enable_q <= 1'b0;
                        alu_rw_q     <= 1'b0;
                        alu_opcode_q <= op_q;
                        alu_in_q     <= '0;
                    end else begin
                        state_q      <= S_WR_B;
                        alu_in_q     <= b_q;
                    end
                end
                S_WR_B: begin
                    state_q      <= S_OP;
                    alu_enable_q <= 1'b0;
                    alu_rw_q     <= 1'b0;
                    alu_opcode_q <= op_q;
                    alu_in_q     <= '0;
                end
                S_OP: begin
                    // Status is not looked at here; the ALU may still be latching the op
                    state_q      <= S_WAIT;
                    alu_opcode_q <= 8'h00;
                    to_cnt_q     <= '0;
                end
                S_WAIT: begin
                    if (!bus.alu_status) begin
                        state_q      <= S_RD;
                        alu_enable_q <= 1'b1;
                        alu_rw_q     <= 1'b1;
                        alu_opcode_q <= (op_q == OP_SCALE) ? scalar_q : OP_DATA;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        // Busy for TIMEOUT cycles: abort without a read cycle
                        state_q     <= S_DONE;
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                        res_data_q  <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_RD: begin
                    state_q      <= S_CAP;
                    alu_enable_q <= 1'b0;
                    alu_rw_q     <= 1'b0;
                    alu_opcode_q <= 8'h00;
                end
                S_CAP: begin
                    state_q     <= S_DONE;
                    res_valid_q <= 1'b1;
                    res_data_q  <= bus.alu_out;
                end
                S_DONE: begin
                    // cmd_ready rises only after this edge, so no same-edge accept
                    if (bus.res_ready) begin
                        state_q     <= S_IDLE;
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_ERR: begin
                    state_q     <= S_DONE;
                    res_valid_q <= 1'b1;
                    res_err_q   <= 1'b1;
                    res_data_q  <= '0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    cmd_ready_q  <= 1'b1;
                    res_valid_q  <= 1'b0;
                    alu_enable_q <= 1'b0;
                    alu_rw_q     <= 1'b0;
                    alu_opcode_q <= 8'h00;
                    alu_in_q     <= '0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_err    = res_err_q;
    assign bus.res_data   = res_data_q;
    assign bus.alu_enable = alu_enable_q;
    assign bus.alu_rw     = alu_rw_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_in     = alu_in_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Bench for alu_cmd_initiator: a mock matrix ALU on the bus, a bus monitor,
// a table of directed commands, a reset-in-WAIT sequence and random commands
// checked against a matrix reference model.
module tb_alu_cmd_initiator;

  localparam int W = 256;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] dbg_state;

  alu_cmd_if #(.DATA_W(W)) bus_if ();

  alu_cmd_initiator #(.DATA_W(W), .TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- matrix reference model ----------------
  function automatic logic [15:0] el(input logic [W-1:0] m, input int k);
    return m[16*k +: 16];
  endfunction

  function automatic logic [W-1:0] mat_ref(input logic [7:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [7:0] s);
    logic [W-1:0] r;
    logic [15:0] acc;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        int k;
        k = row * 4 + col;
        case (op)
          8'h81: r[16*k +: 16] = el(a, k) + el(b, k);
          8'h82: r[16*k +: 16] = el(a, k) - el(b, k);
          8'h83: begin
            acc = 16'h0;
            for (int j = 0; j < 4; j++) acc = acc + el(a, row*4 + j) * el(b, j*4 + col);
            r[16*k +: 16] = acc;
          end
          8'h85: r[16*k +: 16] = el(a, col*4 + row);
          8'hBC: r[16*k +: 16] = el(a, k) * {8'h00, s};
          default: r[16*k +: 16] = 16'h0;
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_mat();
    logic [W-1:0] m;
    for (int k = 0; k < 8; k++) m[32*k +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [W-1:0] fill16(input logic [15:0] v);
    logic [W-1:0] m;
    for (int k = 0; k < 16; k++) m[16*k +: 16] = v;
    return m;
  endfunction

  // ---------------- mock matrix ALU ----------------
  // Operand writes land in A then B; the opcode cycle arms the busy counter;
  // a read cycle returns the computed result (read opcode carries the scale factor).
  int busy_cfg = 0;
  bit stuck = 1'b0;
  int busy_cnt = 0;
  int wr_idx = 0;
  logic [W-1:0] m_a, m_b;
  logic [7:0] m_op;

  assign bus_if.alu_status = stuck || (busy_cnt != 0);

  always @(posedge clk) begin
    if (bus_if.alu_enable && !bus_if.alu_rw && bus_if.alu_opcode == 8'h01) begin
      if (wr_idx == 0) m_a <= bus_if.alu_in;
      else m_b <= bus_if.alu_in;
      wr_idx <= wr_idx ^ 1;
    end
    if (!bus_if.alu_enable && bus_if.alu_opcode != 8'h00) begin
      m_op <= bus_if.alu_opcode;
      busy_cnt <= busy_cfg;
      wr_idx <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (bus_if.alu_enable && bus_if.alu_rw)
      bus_if.alu_out <= mat_ref(m_op, m_a, m_b, bus_if.alu_opcode);
  end

  // ---------------- bus monitor ----------------
  int n_wr, n_rd;
  logic [7:0] op_opc, rd_opc;

  always @(negedge clk) begin
    if (bus_if.alu_enable && !bus_if.alu_rw) n_wr++;
    if (bus_if.alu_enable && bus_if.alu_rw) begin
      n_rd++;
      rd_opc = bus_if.alu_opcode;
    end
    if (!bus_if.alu_enable && bus_if.alu_opcode != 8'h00) op_opc = bus_if.alu_opcode;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stuck = 1'b0;
    busy_cfg = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Offers a command and returns once it has been accepted (#1 after the accept edge).
  task automatic start_cmd(input logic [7:0] op, input logic [7:0] s,
                           input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int n;
    @(negedge clk);
    n_wr = 0; n_rd = 0; op_opc = 8'h00; rd_opc = 8'h00;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op = op;
    bus_if.cmd_scalar = s;
    bus_if.cmd_a = a;
    bus_if.cmd_b = b;
    n = 0;
    while (!bus_if.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus_if.cmd_ready;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_wait: cmd_ready never rose within 50 cycles");
      bus_if.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_a = rand_mat();
    bus_if.cmd_b = rand_mat();
    check("ready_low_after_accept", W'(bus_if.cmd_ready), W'(1'b0));
    check("err_clear_on_accept", W'(bus_if.res_err), W'(1'b0));
  endtask

  // Full command: accept, latency, result, bus activity, back-pressure, handshake.
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] s,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int busy, input bit stk, input int hold,
                         input logic [W-1:0] exp_data, input bit exp_err, input int exp_lat);
    bit ok;
    int lat;
    bit unary, invalid;
    logic [W-1:0] d0;
    logic e0;
    int exp_wr, exp_rd;
    logic [7:0] exp_op, exp_rdop;
    unary = (op == 8'h85) || (op == 8'hBC);
    invalid = 1'b0;
`ifdef ALU_OP_CHECK_EN
    invalid = !(op == 8'h81 || op == 8'h82 || op == 8'h83 || unary);
`endif
    exp_wr = invalid ? 0 : (unary ? 1 : 2);
    exp_rd = (invalid || exp_err) ? 0 : 1;
    exp_op = invalid ? 8'h00 : op;
    exp_rdop = (invalid || exp_err) ? 8'h00 : ((op == 8'hBC) ? s : 8'h01);
    exp_q.push_back(exp_data);
    busy_cfg = busy;
    stuck = stk;
    start_cmd(op, s, a, b, ok);
    if (!ok) begin
      void'(exp_q.pop_front());
      do_reset();
      return;
    end
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (bus_if.res_valid) begin
        lat = n;
        break;
      end
    end
    stuck = 1'b0;
    busy_cfg = 0;
    if (lat == 0) begin
      tests++; fails++;
      $display("FAIL res_valid_wait: no result within 60 cycles (op %0h)", op);
      void'(exp_q.pop_front());
      do_reset();
      return;
    end
    check($sformatf("latency_op%0h", op), W'(lat), W'(exp_lat));
    check($sformatf("res_data_op%0h", op), bus_if.res_data, exp_q.pop_front());
    check($sformatf("res_err_op%0h", op), W'(bus_if.res_err), W'(exp_err));
    check($sformatf("n_wr_op%0h", op), W'(n_wr), W'(exp_wr));
    check($sformatf("n_rd_op%0h", op), W'(n_rd), W'(exp_rd));
    check($sformatf("op_opcode_op%0h", op), W'(op_opc), W'(exp_op));
    check($sformatf("rd_opcode_op%0h", op), W'(rd_opc), W'(exp_rdop));
    d0 = bus_if.res_data;
    e0 = bus_if.res_err;
    // Back-pressure: result held, a new command is not taken
    for (int k = 0; k < hold; k++) begin
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op = 8'h81;
      @(posedge clk);
      #1;
      check("hold_valid", W'(bus_if.res_valid), W'(1'b1));
      check("hold_data", bus_if.res_data, d0);
      check("hold_err", W'(bus_if.res_err), W'(e0));
      check("hold_cmd_ready", W'(bus_if.cmd_ready), W'(1'b0));
    end
    bus_if.cmd_valid = 1'b0;
    bus_if.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.res_ready = 1'b0;
    check("done_valid_drop", W'(bus_if.res_valid), W'(1'b0));
    check("done_cmd_ready", W'(bus_if.cmd_ready), W'(1'b1));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] op;
    logic [7:0] scalar;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int busy;
    bit stuck;
    int hold;
    logic [W-1:0] exp_data;
    bit exp_err;
    int exp_lat;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    logic [W-1:0] ident, ramp, ra, rb;
    logic [7:0] ops [0:4];
    bit ok;

    ident = '0;
    for (int r = 0; r < 4; r++) ident[16*(r*5) +: 16] = 16'h0001;
    for (int k = 0; k < 16; k++) ramp[16*k +: 16] = 16'(k);

    // Latency from the accept edge: writes (2 binary / 1 unary) + OP + WAIT
    // cycles + RD + CAP, i.e. 6 / 5 with status low, +N for N busy WAIT cycles;
    // a timeout lands after TIMEOUT WAIT cycles with no read.
    vecs[0] = '{8'h81, 8'h00, fill16(16'h0001), fill16(16'h0002), 0, 1'b0, 0,
                fill16(16'h0003), 1'b0, 6};
    vecs[1] = '{8'hBC, 8'h09, fill16(16'h0002), fill16(16'hFFFF), 0, 1'b0, 1,
                fill16(16'h0012), 1'b0, 5};
    vecs[2] = '{8'h82, 8'h00, fill16(16'h0005), fill16(16'h0002), 3, 1'b0, 0,
                fill16(16'h0003), 1'b0, 9};
    vecs[3] = '{8'h83, 8'h00, ramp, ramp, 0, 1'b1, 2,
                '0, 1'b1, 3 + TIMEOUT};
    vecs[4] = '{8'h85, 8'h00, ramp, fill16(16'h1234), 0, 1'b0, 0,
                mat_ref(8'h85, ramp, '0, 8'h00), 1'b0, 5};
    vecs[5] = '{8'h83, 8'h00, ident, ramp, 1, 1'b0, 5,
                ramp, 1'b0, 7};

    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op = 8'h00;
    bus_if.cmd_scalar = 8'h00;
    bus_if.cmd_a = '0;
    bus_if.cmd_b = '0;
    bus_if.res_ready = 1'b0;
    reset = 1'b1;
    #1;
    // Reset state
    check("rst_cmd_ready", W'(bus_if.cmd_ready), W'(1'b1));
    check("rst_res_valid", W'(bus_if.res_valid), W'(1'b0));
    check("rst_res_err", W'(bus_if.res_err), W'(1'b0));
    check("rst_res_data", bus_if.res_data, '0);
    check("rst_alu_enable", W'(bus_if.alu_enable), W'(1'b0));
    check("rst_alu_rw", W'(bus_if.alu_rw), W'(1'b0));
    check("rst_alu_opcode", W'(bus_if.alu_opcode), W'(8'h00));
    check("rst_alu_in", bus_if.alu_in, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].op, vecs[i].scalar, vecs[i].a, vecs[i].b, vecs[i].busy,
              vecs[i].stuck, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);

    // Reset asserted while the FSM sits in WAIT (ALU stuck busy)
    stuck = 1'b1;
    start_cmd(8'h82, 8'h00, fill16(16'h0007), fill16(16'h0001), ok);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midwait_rst_cmd_ready", W'(bus_if.cmd_ready), W'(1'b1));
    check("midwait_rst_enable", W'(bus_if.alu_enable), W'(1'b0));
    check("midwait_rst_res_valid", W'(bus_if.res_valid), W'(1'b0));
    stuck = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_cmd(8'h81, 8'h00, fill16(16'h0010), fill16(16'h0020), 0, 1'b0, 0,
            fill16(16'h0030), 1'b0, 6);

`ifdef ALU_OP_CHECK_EN
    // Unknown opcode: error result, no ALU bus activity
    run_cmd(8'h90, 8'h00, ramp, ramp, 0, 1'b0, 1, '0, 1'b1, 1);
`endif

    // Random commands against the reference model
    ops[0] = 8'h81; ops[1] = 8'h82; ops[2] = 8'h83; ops[3] = 8'h85; ops[4] = 8'hBC;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] op, s;
      int busy;
      bit un;
      op = ops[$urandom_range(0, 4)];
      s = 8'($urandom);
      ra = rand_mat();
      rb = rand_mat();
      busy = $urandom_range(0, 3);
      un = (op == 8'h85) || (op == 8'hBC);
      run_cmd(op, s, ra, rb, busy, 1'b0, $urandom_range(0, 3),
              mat_ref(op, ra, rb, s), 1'b0, (un ? 5 : 6) + busy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
